// File: rtl/conv_out_stage.sv
// Output stage after conv_3x3: per-lane int32 -> int8 requantization, packing of the
// 8 lanes into one 64-bit beat, and an optional 2x2 max-pool (stride 2 or stride 1).
module conv_out_stage #(
  parameter int MAX_WIDTH  = 416,
  parameter int QUANT_PIPE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cfg_quant_m,
  input  logic [4:0]  cfg_quant_n,
  input  logic        cfg_use_relu,
  input  logic        cfg_use_maxpool,
  input  logic        cfg_stride_2,
  input  logic [15:0] cfg_out_width,
  input  logic [15:0] cfg_out_height,
  input  logic [31:0] conv_outs [0:7],
  input  logic        conv_valid,
  output logic [63:0] data_out,
  output logic        data_out_valid,
  output logic        frame_done
);

  // Handshake: conv_valid and data_out_valid each qualify a single beat in the cycle they
  // are high; there is no backpressure, so the consumer must accept every valid beat.

  localparam int AW = $clog2(MAX_WIDTH);

  logic [QUANT_PIPE-1:0] r_vld;
  logic signed [64:0]    r_p [8];
  logic signed [64:0]    r_q [8];
  logic [63:0]           r_s3;
  logic [15:0]           r_col;
  logic [15:0]           r_row;
  logic [63:0]           r_prev;
  logic [63:0]           r_row_buf [MAX_WIDTH];
  logic [63:0]           r_pool_data;
  logic                  r_pool_valid;
  logic                  r_pool_done;

  logic                  w_clear;
  logic signed [64:0]    w_rnd;
  logic signed [64:0]    w_prod [8];
  logic signed [64:0]    w_q [8];
  logic [63:0]           w_sat;
  logic                  w_s3v;
  logic                  w_col_last;
  logic                  w_last;
  logic [AW-1:0]         w_idx;
  logic [63:0]           w_buf_rd;
  logic [63:0]           w_pair;
  logic [63:0]           w_h;
  logic [63:0]           w_pool;
  logic                  w_emit;
  logic                  w_wr_en;
  logic [63:0]           w_wr_data;

  function automatic logic [63:0] lane_max(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = ($signed(a[8*i +: 8]) > $signed(b[8*i +: 8])) ? a[8*i +: 8] : b[8*i +: 8];
    end
    return m;
  endfunction

  // start behaves like a frame-level reset: counters and in-flight beats are dropped.
  assign w_clear = rst | start;

  always_comb begin
    w_rnd = '0;
    if (cfg_quant_n != 5'd0) w_rnd = 65'sd1 <<< (cfg_quant_n - 5'd1);
    w_sat = '0;
    for (int i = 0; i < 8; i++) begin
      w_prod[i] = $signed({{33{conv_outs[i][31]}}, conv_outs[i]}) * $signed({33'd0, cfg_quant_m});
      w_q[i]    = (r_p[i] + w_rnd) >>> cfg_quant_n;
      if (cfg_use_relu && (r_q[i] < 65'sd0)) w_sat[8*i +: 8] = 8'h00;
      else if (r_q[i] > 65'sd127)            w_sat[8*i +: 8] = 8'h7f;
      else if (r_q[i] < -65'sd128)           w_sat[8*i +: 8] = 8'h80;
      else                                   w_sat[8*i +: 8] = r_q[i][7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) r_vld <= '0;
    else         r_vld <= {r_vld[QUANT_PIPE-2:0], conv_valid};
    for (int i = 0; i < 8; i++) begin
      if (conv_valid) r_p[i] <= w_prod[i];
      if (r_vld[0])   r_q[i] <= w_q[i];
    end
    if (rst)           r_s3 <= '0;
    else if (r_vld[1]) r_s3 <= w_sat;
  end

  // Stride 2 keeps one buffer entry per column pair, stride 1 one entry per column.
  always_comb begin
    w_s3v      = r_vld[QUANT_PIPE-1];
    w_col_last = (r_col == cfg_out_width - 16'd1);
    w_last     = w_col_last && (r_row == cfg_out_height - 16'd1);
    w_idx      = (cfg_use_maxpool && cfg_stride_2) ? r_col[AW:1] : r_col[AW-1:0];
    w_buf_rd   = r_row_buf[w_idx];
    w_pair     = lane_max(r_s3, r_prev);
    w_h        = (r_col == 16'd0) ? r_s3 : w_pair;
    if (cfg_stride_2) begin
      w_emit    = r_row[0] & r_col[0];
      w_pool    = lane_max(w_buf_rd, w_pair);
      w_wr_en   = w_s3v & cfg_use_maxpool & ~r_row[0] & r_col[0];
      w_wr_data = w_pair;
    end else begin
      w_emit    = 1'b1;
      w_pool    = (r_row == 16'd0) ? w_h : lane_max(w_h, w_buf_rd);
      w_wr_en   = w_s3v & cfg_use_maxpool;
      w_wr_data = w_h;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_s3v) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_last ? 16'd0 : r_row + 16'd1;
      end else begin
        r_col <= r_col + 16'd1;
      end
    end
    if (rst)        r_prev <= '0;
    else if (w_s3v) r_prev <= r_s3;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_row_buf[w_idx] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_pool_valid <= 1'b0;
      r_pool_done  <= 1'b0;
    end else begin
      r_pool_valid <= w_s3v & w_emit;
      r_pool_done  <= w_s3v & w_last;
    end
    if (rst)                  r_pool_data <= '0;
    else if (w_s3v && w_emit) r_pool_data <= w_pool;
  end

  always_comb begin
    if (cfg_use_maxpool) begin
      data_out       = r_pool_data;
      data_out_valid = r_pool_valid;
      frame_done     = r_pool_done;
    end else begin
      data_out       = r_s3;
      data_out_valid = w_s3v;
      frame_done     = w_s3v & w_last;
    end
  end

endmodule
